// File: rtl/ddr_rd_arbiter_if.sv
// ddr_rd_arbiter_if
// DDR read-burst bus between the read arbiter and the DDR controller.
//   rd_burst_req        : burst request (arbiter -> DDR)
//   rd_burst_addr       : burst start byte address (arbiter -> DDR)
//   rd_burst_len        : burst length in beats (arbiter -> DDR)
//   rd_burst_data_valid : beat valid (DDR -> arbiter)
//   rd_burst_data       : beat data (DDR -> arbiter)
//   rd_burst_finish     : one-cycle pulse after the last beat (DDR -> arbiter)
// Modports: master = arbiter side, slave = DDR controller side.
interface ddr_rd_arbiter_if #(
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int DATA_WIDTH     = 28,
    parameter int LEN_WIDTH      = 10
);
    logic                      rd_burst_req;
    logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr;
    logic [LEN_WIDTH-1:0]      rd_burst_len;
    logic                      rd_burst_data_valid;
    logic [DATA_WIDTH-1:0]     rd_burst_data;
    logic                      rd_burst_finish;

    modport master (
        output rd_burst_req,
        output rd_burst_addr,
        output rd_burst_len,
        input  rd_burst_data_valid,
        input  rd_burst_data,
        input  rd_burst_finish
    );

    modport slave (
        input  rd_burst_req,
        input  rd_burst_addr,
        input  rd_burst_len,
        output rd_burst_data_valid,
        output rd_burst_data,
        output rd_burst_finish
    );
endinterface

// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter
// Two-client (instruction cache / data cache) arbiter for a single DDR
// read-burst port. Grants one client at a time, round-robin on contention,
// issues the client's burst, forwards beats with one cycle of latency and
// counts delivered beats (saturating at the burst length).
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   isa_req/addr/len    : instruction-cache request, held until done
//   isa_rd_cnt          : beats delivered to the instruction cache
//   isa_data_valid      : beat strobe to the instruction cache
//   dat_req/addr/len    : data-cache request, held until done
//   dat_rd_cnt          : beats delivered to the data cache
//   dat_data_valid      : beat strobe to the data cache
//   rd_data_out         : registered beat data shared by both clients
//   ddr                 : DDR read-burst bus (master side)
//   grant               : current owner, 00 none / 01 ISA / 10 DATA
module ddr_rd_arbiter #(
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int DATA_WIDTH     = 28,
    parameter int LEN_WIDTH      = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      isa_req,
    input  logic [DDR_ADDR_WIDTH-1:0] isa_addr,
    input  logic [LEN_WIDTH-1:0]      isa_len,
    output logic [LEN_WIDTH-1:0]      isa_rd_cnt,
    output logic                      isa_data_valid,
    input  logic                      dat_req,
    input  logic [DDR_ADDR_WIDTH-1:0] dat_addr,
    input  logic [LEN_WIDTH-1:0]      dat_len,
    output logic [LEN_WIDTH-1:0]      dat_rd_cnt,
    output logic                      dat_data_valid,
    output logic [DATA_WIDTH-1:0]     rd_data_out,
    ddr_rd_arbiter_if.master          ddr,
    output logic [1:0]                grant
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        BURST   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_ISA  = 2'b01;
    localparam logic [1:0] GRANT_DAT  = 2'b10;
    localparam logic       PRIO_ISA   = 1'b0;
    localparam logic       PRIO_DAT   = 1'b1;

    state_t                    state_reg, state_next;
    logic [1:0]                grant_reg, grant_next;
    logic                      prio_reg, prio_next;
    logic [DDR_ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [LEN_WIDTH-1:0]      len_reg, len_next;
    logic [LEN_WIDTH-1:0]      isa_cnt_reg, isa_cnt_next;
    logic [LEN_WIDTH-1:0]      dat_cnt_reg, dat_cnt_next;
    logic                      isa_dv_reg, isa_dv_next;
    logic                      dat_dv_reg, dat_dv_next;
    logic [DATA_WIDTH-1:0]     data_reg, data_next;

    logic pick_isa;
    logic owner_req;
    logic beat_window;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            grant_reg   <= GRANT_NONE;
            prio_reg    <= PRIO_ISA;
            addr_reg    <= '0;
            len_reg     <= '0;
            isa_cnt_reg <= '0;
            dat_cnt_reg <= '0;
            isa_dv_reg  <= 1'b0;
            dat_dv_reg  <= 1'b0;
            data_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            prio_reg    <= prio_next;
            addr_reg    <= addr_next;
            len_reg     <= len_next;
            isa_cnt_reg <= isa_cnt_next;
            dat_cnt_reg <= dat_cnt_next;
            isa_dv_reg  <= isa_dv_next;
            dat_dv_reg  <= dat_dv_next;
            data_reg    <= data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        prio_next    = prio_reg;
        addr_next    = addr_reg;
        len_next     = len_reg;
        isa_cnt_next = isa_cnt_reg;
        dat_cnt_next = dat_cnt_reg;
        isa_dv_next  = 1'b0;
        dat_dv_next  = 1'b0;
        data_next    = data_reg;

        // ISA wins when alone, or when both ask and the pointer favours it.
        pick_isa    = isa_req && (!dat_req || (prio_reg == PRIO_ISA));
        owner_req   = (grant_reg == GRANT_ISA) ? isa_req : dat_req;
        beat_window = ((state_reg == ISSUE) || (state_reg == BURST))
                      && ddr.rd_burst_data_valid;

        case (state_reg)
            IDLE: begin
                if (isa_req || dat_req) begin
                    state_next = ISSUE;
                    if (pick_isa) begin
                        grant_next   = GRANT_ISA;
                        addr_next    = isa_addr;
                        len_next     = isa_len;
                        isa_cnt_next = '0;
                    end else begin
                        grant_next   = GRANT_DAT;
                        addr_next    = dat_addr;
                        len_next     = dat_len;
                        dat_cnt_next = '0;
                    end
                end
            end
            ISSUE: begin
                // A zero-length burst never touches the DDR port.
                if (len_reg == '0) begin
                    state_next = RELEASE;
                end else if (ddr.rd_burst_data_valid) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                if (ddr.rd_burst_finish) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!owner_req) begin
                    state_next = IDLE;
                    grant_next = GRANT_NONE;
                    prio_next  = (grant_reg == GRANT_ISA) ? PRIO_DAT : PRIO_ISA;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Beats past the latched length are dropped entirely: no strobe,
        // no count, and rd_data_out keeps the last delivered beat.
        if (beat_window) begin
            if ((grant_reg == GRANT_ISA) && (isa_cnt_reg < len_reg)) begin
                isa_cnt_next = isa_cnt_reg + LEN_WIDTH'(1);
                isa_dv_next  = 1'b1;
                data_next    = ddr.rd_burst_data;
            end
            if ((grant_reg == GRANT_DAT) && (dat_cnt_reg < len_reg)) begin
                dat_cnt_next = dat_cnt_reg + LEN_WIDTH'(1);
                dat_dv_next  = 1'b1;
                data_next    = ddr.rd_burst_data;
            end
        end
    end

    // Request is held from ISSUE entry until the first beat moves us to BURST.
    assign ddr.rd_burst_req  = (state_reg == ISSUE) && (len_reg != '0);
    assign ddr.rd_burst_addr = addr_reg;
    assign ddr.rd_burst_len  = len_reg;

    assign grant          = grant_reg;
    assign isa_rd_cnt     = isa_cnt_reg;
    assign dat_rd_cnt     = dat_cnt_reg;
    assign isa_data_valid = isa_dv_reg;
    assign dat_data_valid = dat_dv_reg;
    assign rd_data_out    = data_reg;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// tb_ddr_rd_arbiter
// Directed bench for ddr_rd_arbiter: single burst, contention and
// round-robin, zero length, overrun and reset mid-burst.
module tb_ddr_rd_arbiter;

    localparam int AW = 28;
    localparam int DW = 28;
    localparam int LW = 10;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_ISA  = 2'b01;
    localparam logic [1:0] G_DAT  = 2'b10;

    logic          clk = 1'b0;
    logic          rst;
    logic          isa_req;
    logic [AW-1:0] isa_addr;
    logic [LW-1:0] isa_len;
    logic [LW-1:0] isa_rd_cnt;
    logic          isa_data_valid;
    logic          dat_req;
    logic [AW-1:0] dat_addr;
    logic [LW-1:0] dat_len;
    logic [LW-1:0] dat_rd_cnt;
    logic          dat_data_valid;
    logic [DW-1:0] rd_data_out;
    logic [1:0]    grant;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] exp_data;

    ddr_rd_arbiter_if #(.DDR_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    ddr_rd_arbiter #(.DDR_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .isa_req        (isa_req),
        .isa_addr       (isa_addr),
        .isa_len        (isa_len),
        .isa_rd_cnt     (isa_rd_cnt),
        .isa_data_valid (isa_data_valid),
        .dat_req        (dat_req),
        .dat_addr       (dat_addr),
        .dat_len        (dat_len),
        .dat_rd_cnt     (dat_rd_cnt),
        .dat_data_valid (dat_data_valid),
        .rd_data_out    (rd_data_out),
        .ddr            (bus.master),
        .grant          (grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".grant"}, 32'(grant), 32'(G_NONE));
        check({tag, ".burst_req"}, 32'(bus.rd_burst_req), 32'd0);
        check({tag, ".burst_addr"}, 32'(bus.rd_burst_addr), 32'd0);
        check({tag, ".burst_len"}, 32'(bus.rd_burst_len), 32'd0);
        check({tag, ".isa_cnt"}, 32'(isa_rd_cnt), 32'd0);
        check({tag, ".dat_cnt"}, 32'(dat_rd_cnt), 32'd0);
        check({tag, ".isa_dv"}, 32'(isa_data_valid), 32'd0);
        check({tag, ".dat_dv"}, 32'(dat_data_valid), 32'd0);
        check({tag, ".data_out"}, 32'(rd_data_out), 32'd0);
    endtask

    // Called one step after the edge that entered ISSUE for 'owner'.
    // Delivers nbeats beats, pulses finish, holds the request one RELEASE
    // cycle, then drops it and ends in IDLE.
    task automatic serve(input logic [1:0] owner, input logic [AW-1:0] addr,
                         input int len, input int nbeats);
        logic [LW-1:0] other_cnt;
        int exp_cnt;
        int pulses;
        logic [DW-1:0] d;
        pulses = 0;
        other_cnt = (owner == G_ISA) ? dat_rd_cnt : isa_rd_cnt;
        check("issue.grant", 32'(grant), 32'(owner));
        check("issue.burst_req", 32'(bus.rd_burst_req), (len != 0) ? 32'd1 : 32'd0);
        check("issue.burst_addr", 32'(bus.rd_burst_addr), 32'(addr));
        check("issue.burst_len", 32'(bus.rd_burst_len), 32'(len));
        check("issue.owner_cnt", 32'((owner == G_ISA) ? isa_rd_cnt : dat_rd_cnt), 32'd0);
        for (int i = 0; i < nbeats; i++) begin
            d = 28'h0ABC000 + addr + 28'(i);
            bus.rd_burst_data_valid = 1'b1;
            bus.rd_burst_data = d;
            tick();
            exp_cnt = (i + 1 < len) ? i + 1 : len;
            if (i < len) begin
                exp_data = d;
                pulses++;
            end
            check("beat.owner_cnt", 32'((owner == G_ISA) ? isa_rd_cnt : dat_rd_cnt), 32'(exp_cnt));
            check("beat.owner_dv", 32'((owner == G_ISA) ? isa_data_valid : dat_data_valid),
                  (i < len) ? 32'd1 : 32'd0);
            check("beat.other_dv", 32'((owner == G_ISA) ? dat_data_valid : isa_data_valid), 32'd0);
            check("beat.other_cnt", 32'((owner == G_ISA) ? dat_rd_cnt : isa_rd_cnt), 32'(other_cnt));
            check("beat.data_out", 32'(rd_data_out), 32'(exp_data));
            check("beat.burst_req", 32'(bus.rd_burst_req), 32'd0);
        end
        bus.rd_burst_data_valid = 1'b0;
        bus.rd_burst_finish = 1'b1;
        tick();
        bus.rd_burst_finish = 1'b0;
        check("fin.owner_dv", 32'((owner == G_ISA) ? isa_data_valid : dat_data_valid), 32'd0);
        check("fin.burst_req", 32'(bus.rd_burst_req), 32'd0);
        check("fin.pulses", 32'(pulses), 32'((nbeats < len) ? nbeats : len));
        tick();
        check("rel.grant_held", 32'(grant), 32'(owner));
        check("rel.burst_addr", 32'(bus.rd_burst_addr), 32'(addr));
        if (owner == G_ISA) isa_req = 1'b0;
        else dat_req = 1'b0;
        tick();
        check("idle.grant", 32'(grant), 32'(G_NONE));
        check("idle.burst_req", 32'(bus.rd_burst_req), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        isa_req = 1'b0; isa_addr = '0; isa_len = '0;
        dat_req = 1'b0; dat_addr = '0; dat_len = '0;
        bus.rd_burst_data_valid = 1'b0;
        bus.rd_burst_data = '0;
        bus.rd_burst_finish = 1'b0;
        exp_data = '0;

        tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // Single ISA burst of 4 beats at 0x80.
        isa_req = 1'b1; isa_addr = 28'h80; isa_len = 10'd4;
        tick();
        serve(G_ISA, 28'h80, 4, 4);

        // Fresh reset, then simultaneous requests and round-robin.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_data = '0;
        tick();
        isa_req = 1'b1; isa_addr = 28'h100; isa_len = 10'd1;
        dat_req = 1'b1; dat_addr = 28'h200; dat_len = 10'd2;
        tick();
        serve(G_ISA, 28'h100, 1, 1);
        tick();
        serve(G_DAT, 28'h200, 2, 2);
        isa_req = 1'b1;
        dat_req = 1'b1;
        tick();
        serve(G_ISA, 28'h100, 1, 1);
        tick();
        serve(G_DAT, 28'h200, 2, 2);

        // Zero-length data burst.
        dat_req = 1'b1; dat_addr = 28'h300; dat_len = 10'd0;
        tick();
        serve(G_DAT, 28'h300, 0, 0);

        // Overrun: 3 beats against a length of 2.
        isa_req = 1'b1; isa_addr = 28'h400; isa_len = 10'd2;
        tick();
        serve(G_ISA, 28'h400, 2, 3);

        // Reset mid-burst after 2 of 8 beats.
        isa_req = 1'b1; isa_addr = 28'h500; isa_len = 10'd8;
        tick();
        check("mid.grant", 32'(grant), 32'(G_ISA));
        for (int i = 0; i < 2; i++) begin
            bus.rd_burst_data_valid = 1'b1;
            bus.rd_burst_data = 28'h0123450 + 28'(i);
            tick();
            check("mid.isa_cnt", 32'(isa_rd_cnt), 32'(i + 1));
        end
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        tick();
        isa_req = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.rd_burst_data_valid = 1'b1;
            bus.rd_burst_data = 28'h0FFF000 + 28'(i);
            bus.rd_burst_finish = (i == 2);
            tick();
            check("stray.isa_dv", 32'(isa_data_valid), 32'd0);
            check("stray.dat_dv", 32'(dat_data_valid), 32'd0);
            check("stray.isa_cnt", 32'(isa_rd_cnt), 32'd0);
            check("stray.grant", 32'(grant), 32'(G_NONE));
            check("stray.data_out", 32'(rd_data_out), 32'd0);
        end
        bus.rd_burst_data_valid = 1'b0;
        bus.rd_burst_finish = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddr_rd_arbiter.md
DDR_RD_ARBITER -- requirements
Module: ddr_rd_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DDR_ADDR_WIDTH, 28, DDR byte address width.
- DATA_WIDTH, 28, burst data word width (ISA word width).
- LEN_WIDTH, 10, burst length and beat counter width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-low reset.
- isa_req, in, 1, instruction-cache read request; held until done.
- isa_addr, in, DDR_ADDR_WIDTH, instruction-cache burst start address.
- isa_len, in, LEN_WIDTH, instruction-cache burst length in beats.
- isa_rd_cnt, out, LEN_WIDTH, beats delivered to the instruction cache.
- isa_data_valid, out, 1, beat strobe to the instruction cache.
- dat_req, in, 1, data-cache read request; held until done.
- dat_addr, in, DDR_ADDR_WIDTH, data-cache burst start address.
- dat_len, in, LEN_WIDTH, data-cache burst length in beats.
- dat_rd_cnt, out, LEN_WIDTH, beats delivered to the data cache.
- dat_data_valid, out, 1, beat strobe to the data cache.
- rd_data_out, out, DATA_WIDTH, registered beat data, shared by both clients.
- rd_burst_req, out, 1, DDR read burst request.
- rd_burst_addr, out, DDR_ADDR_WIDTH, DDR burst address.
- rd_burst_len, out, LEN_WIDTH, DDR burst length.
- rd_burst_data_valid, in, 1, DDR beat valid.
- rd_burst_data, in, DATA_WIDTH, DDR beat data.
- rd_burst_finish, in, 1, one-cycle pulse after the last beat.
- grant, out, 2, current owner: 00 none, 01 ISA, 10 DATA.

Function
REQ-003 The block SHALL use a state machine with states IDLE, ISSUE, BURST and RELEASE.

REQ-004 In IDLE, when one or more requests are high, the block SHALL go to ISSUE on the next edge and update grant.
- Only one request high: grant that requester.
- Both requests high: grant the requester indicated by the round-robin pointer `prio`.

REQ-005 On entry to ISSUE, the block SHALL latch the winner's addr and len into rd_burst_addr and rd_burst_len, and clear that winner's rd_cnt to 0.

REQ-006 In ISSUE, rd_burst_req SHALL be 1, and the state SHALL remain ISSUE until the first rd_burst_data_valid, then go to BURST.
- rd_burst_req SHALL drop to 0 in the cycle after that first beat.

REQ-007 If the latched len equals 0, the block SHALL go from ISSUE directly to RELEASE without asserting rd_burst_req.

REQ-008 On every rd_burst_data_valid beat while granted (ISSUE or BURST):
- register rd_burst_data into rd_data_out;
- pulse the owner's *_data_valid for one cycle;
- increment the owner's rd_cnt by 1.
- Latency from the DDR beat to the client strobe SHALL be 1 cycle.

REQ-009 The rd_cnt counters SHALL saturate at the latched len; extra beats SHALL be dropped and SHALL NOT strobe the client.

REQ-010 The non-owner's data_valid SHALL stay 0, and its rd_cnt SHALL hold its value.

REQ-011 In BURST, rd_burst_finish SHALL move the state to RELEASE.

REQ-012 In RELEASE, the block SHALL wait until the owner's req is 0, then go to IDLE.
- On that transition: grant returns to 00, and `prio` points to the other requester.

REQ-013 The block SHALL ignore a request that rises while the other requester owns the port until the state returns to IDLE. The new request SHALL then win on the IDLE cycle (no starvation).

REQ-014 A rd_burst_data_valid or rd_burst_finish seen in IDLE or RELEASE SHALL be ignored: no strobe, no counter change, no state change.

REQ-015 The block SHALL keep rd_burst_addr and rd_burst_len stable from ISSUE until leaving RELEASE.

Reset
REQ-016 While rst is 0, the block SHALL force:
- state to IDLE and grant to 00;
- rd_burst_req to 0, rd_burst_addr to 0, rd_burst_len to 0;
- both rd_cnt to 0 and both data_valid to 0;
- rd_data_out to 0;
- `prio` to ISA.

REQ-017 Reset asserted mid-burst SHALL abort the burst immediately. After rst rises, no beat SHALL be forwarded until a new grant is made.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Single ISA burst: isa_req=1, isa_addr=0x80, isa_len=4, DDR returns 4 beats then finish -> rd_burst_addr=0x80, rd_burst_len=4; isa_rd_cnt steps 1,2,3,4 one cycle after each beat; state returns to IDLE after isa_req drops.
- Simultaneous requests after reset: isa_req and dat_req rise in the same cycle -> grant=01 first. After that release, grant=10 with no IDLE stall beyond 1 cycle.
- Round-robin: two back-to-back contended rounds -> grants alternate 01,10,01,10.
- Zero length: dat_len=0 -> rd_burst_req never asserted; grant=10 then 00 once dat_req drops.
- Overrun: isa_len=2 and DDR returns 3 beats -> isa_rd_cnt stays at 2; exactly 2 isa_data_valid pulses.
- Reset mid-burst: rst=0 after 2 of 8 beats -> all outputs at reset values; subsequent stray beats produce no strobe.
